prog_loader: RTL and testbench

- Hardware program-image loader: accepts a byte stream over a valid/ready handshake and writes little-endian 32-bit words into the CPU's unified memory (dm) write port.
- Holds the CPU in reset until the image is fully written.
- Replaces the simulation-only memory preload with a synthesizable path; sits between the host/UART byte source and the memory write port, beside the cpu.

---
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program image loader writing 32-bit words into CPU memory
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned            MAX_WORDS = (1 << ADDR_WIDTH) - BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0]  BASE      = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] remaining;
    logic [1:0]  byte_idx;
    logic        take;
    logic        restart;
    logic [15:0] hdr_count;

    assign take      = in_valid & in_ready;
    assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    // Low header byte is parked in remaining[7:0] until the high byte arrives.
    assign hdr_count = {in_data, remaining[7:0]};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: header parse, oversize check, word assembly and write sequencing.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) next_state = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (take) next_state = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (take) begin
                    if (hdr_count == 16'd0)
                        next_state = S_DONE;
                    else if (32'(hdr_count) > MAX_WORDS)
                        next_state = S_ERROR;
                    else
                        next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (take && byte_idx == 2'd3) next_state = S_WRITE;
            end
            S_WRITE: begin
                next_state = (remaining == 16'd1) ? S_DONE : S_DATA;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Registered outputs and datapath; flags follow the state being entered so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            remaining  <= 16'd0;
            byte_idx   <= 2'd0;
        end else begin
            in_ready <= (next_state == S_HDR_LO) || (next_state == S_HDR_HI) || (next_state == S_DATA);
            mem_we   <= (next_state == S_WRITE);
            done     <= (next_state == S_DONE);
            error    <= (next_state == S_ERROR);
            cpu_hold <= (next_state != S_DONE);

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (restart) begin
                        word_count <= '0;
                        byte_idx   <= 2'd0;
                        mem_addr   <= BASE;
                    end
                end
                S_HDR_LO: begin
                    if (take) remaining <= {8'h00, in_data};
                end
                S_HDR_HI: begin
                    if (take) remaining <= hdr_count;
                end
                S_DATA: begin
                    if (take) begin
                        case (byte_idx)
                            2'd0:    mem_wdata[7:0]   <= in_data;
                            2'd1:    mem_wdata[15:8]  <= in_data;
                            2'd2:    mem_wdata[23:16] <= in_data;
                            default: mem_wdata[31:24] <= in_data;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                    word_count <= word_count + (ADDR_WIDTH + 1)'(1);
                    remaining  <= remaining - 16'd1;
                    byte_idx   <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int checks      = 0;
    int errors      = 0;
    int gap_stalls  = 0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    logic [7:0] img2[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] img1[6]  = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};

    prog_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Memory write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) begin
            if (!in_ready && !mem_we) gap_stalls++;
            @(negedge clk);
        end
    endtask

    task automatic send_img2(input int gap);
        for (int i = 0; i < 10; i++) send_byte(img2[i], (i == 9) ? 0 : gap);
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"},   wa.size(), 2);
        check({tag, "_addr0"}, wa[0], 0);
        check({tag, "_data0"}, wd[0], 32'h12345678);
        check({tag, "_addr1"}, wa[1], 1);
        check({tag, "_data1"}, wd[1], 32'hDEADBEEF);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_mem_we"},     mem_we,     0);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_mem_wdata"},  mem_wdata,  0);
        check({tag, "_cpu_hold"},   cpu_hold,   1);
        check({tag, "_done"},       done,       0);
        check({tag, "_error"},      error,      0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Two-word load, valid held high; check write latency directly.
        pulse_start();
        check("t1_ready_hdr", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            send_byte(img2[i], 0);
            if (i == 5) begin
                check("t1_lat_we",   mem_we,    1);
                check("t1_lat_addr", mem_addr,  0);
                check("t1_lat_data", mem_wdata, 32'h12345678);
                check("t1_lat_rdy",  in_ready,  0);
            end
        end
        check("t1_we_last", mem_we, 1);
        check("t1_done_pre", done, 0);
        @(negedge clk);
        check("t1_done",   done,       1);
        check("t1_hold",   cpu_hold,   0);
        check("t1_wc",     word_count, 2);
        check("t1_ready",  in_ready,   0);
        check_two_writes("t1");
        // Extra byte after the image is not accepted.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("t1_extra_rdy", in_ready, 0);
        check("t1_extra_nwr", wa.size(), 2);
        in_valid = 1'b0;

        // Zero-length header; start from DONE reasserts hold as done clears.
        wa.delete(); wd.delete();
        pulse_start();
        check("t2_done_clr", done, 0);
        check("t2_hold_set", cpu_hold, 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t2_done", done, 1);
        check("t2_hold", cpu_hold, 0);
        check("t2_wc",   word_count, 0);
        repeat (2) @(negedge clk);
        check("t2_nwr",  wa.size(), 0);

        // Backpressure: three idle cycles between every byte.
        wa.delete(); wd.delete();
        pulse_start();
        gap_stalls = 0;
        send_img2(3);
        @(negedge clk);
        check("t3_stalls", gap_stalls, 0);
        check("t3_done",   done, 1);
        check("t3_hold",   cpu_hold, 0);
        check("t3_wc",     word_count, 2);
        check_two_writes("t3");

        // Oversize header (17 > 16 words), then recovery with a one-word image.
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        check("t4_error", error, 1);
        check("t4_hold",  cpu_hold, 1);
        check("t4_ready", in_ready, 0);
        check("t4_done",  done, 0);
        repeat (3) @(negedge clk);
        check("t4_nwr",   wa.size(), 0);
        pulse_start();
        check("t4_err_clr", error, 0);
        for (int i = 0; i < 6; i++) send_byte(img1[i], 0);
        @(negedge clk);
        check("t4_done2",  done, 1);
        check("t4_error2", error, 0);
        check("t4_wc2",    word_count, 1);
        check("t4_nwr2",   wa.size(), 1);
        check("t4_addr2",  wa[0], 0);
        check("t4_data2",  wd[0], 32'h11223344);

        // Exactly-full header (16 words) is accepted; reset mid-load after 5 data bytes.
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        check("t5_full_err", error, 0);
        check("t5_full_rdy", in_ready, 1);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 0);
        check("t5_mid_addr", mem_addr, 1);
        check("t5_mid_wc",   word_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("t5_async");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        send_img2(0);
        @(negedge clk);
        check("t5_done", done, 1);
        check("t5_wc",   word_count, 2);
        check_two_writes("t5");

        // start during DATA is ignored.
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(img2[i], 0);
        pulse_start();
        check("t6_ready", in_ready, 1);
        for (int i = 4; i < 10; i++) send_byte(img2[i], 0);
        @(negedge clk);
        check("t6_done", done, 1);
        check("t6_wc",   word_count, 2);
        check_two_writes("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
